// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: self-scanning multiplexed 7-segment driver with frame snapshot, PWM and zero suppression
// ports: clk/rst (sync, active-high); hexs, points, les, lz_en snapshotted once per frame;
//        bright live 4-bit PWM level; an active-low digit enables; segment {p,g..a} active-low;
//        frame_tick one-cycle pulse on each snapshot load
module seg7_scan_driver #(
  parameter int DIGITS   = 4,
  parameter int DIV_LOG2 = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   hexs,
  input  logic [DIGITS-1:0]     points,
  input  logic [DIGITS-1:0]     les,
  input  logic                  lz_en,
  input  logic [3:0]            bright,
  output logic [DIGITS-1:0]     an,
  output logic [7:0]            segment,
  output logic                  frame_tick
);
  localparam int SW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  logic [DIV_LOG2-1:0]    p_q, p_d;
  logic [SW-1:0]          sel_q, sel_d;
  logic [DIGITS-1:0][3:0] hex_q, hex_d;
  logic [DIGITS-1:0]      pt_q, pt_d, le_q, le_d, lz_blank;
  logic                   lz_q, lz_d, load_pending_q, load_pending_d, frame_tick_q, frame_tick_d;
  logic [DIGITS-1:0]      an_q, an_d;
  logic [7:0]             seg_q, seg_d;
  logic                   tick, load, on, zero_above;
  logic [3:0]             nib;
  // a digit is suppressed when it and every more-significant digit are zero; digit 0 always shows
  always_comb begin
    zero_above = 1'b1;
    lz_blank   = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_above  = zero_above & (hex_q[i] == 4'h0);
      lz_blank[i] = lz_q & zero_above & (i != 0);
    end
  end
  // outputs are built from the current sel/p/snapshot together, so an and segment always switch in the same cycle
  always_comb begin
    tick           = &p_q;
    load           = (tick && sel_q == SW'(DIGITS - 1)) || load_pending_q;
    p_d            = p_q + 1'b1;
    sel_d          = tick ? (sel_q == SW'(DIGITS - 1) ? '0 : sel_q + 1'b1) : sel_q;
    hex_d          = load ? hexs : hex_q;
    pt_d           = load ? points : pt_q;
    le_d           = load ? les : le_q;
    lz_d           = load ? lz_en : lz_q;
    load_pending_d = 1'b0;
    frame_tick_d   = load;
    nib            = hex_q[sel_q];
    on             = p_q[DIV_LOG2-1 -: 4] <= bright;
    an_d           = on ? ~(DIGITS'(1) << sel_q) : '1;
    seg_d          = on ? {~pt_q[sel_q], (le_q[sel_q] | lz_blank[sel_q]) ? 7'h7F : SEG_LUT[nib]} : 8'hFF;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      p_q            <= '0;
      sel_q          <= '0;
      hex_q          <= '0;
      pt_q           <= '0;
      le_q           <= '0;
      lz_q           <= 1'b0;
      load_pending_q <= 1'b1;
      frame_tick_q   <= 1'b0;
      an_q           <= '1;
      seg_q          <= 8'hFF;
    end else begin
      p_q            <= p_d;
      sel_q          <= sel_d;
      hex_q          <= hex_d;
      pt_q           <= pt_d;
      le_q           <= le_d;
      lz_q           <= lz_d;
      load_pending_q <= load_pending_d;
      frame_tick_q   <= frame_tick_d;
      an_q           <= an_d;
      seg_q          <= seg_d;
    end
  end
  assign an         = an_q;
  assign segment    = seg_q;
  assign frame_tick = frame_tick_q;
endmodule
